// File: rtl/spi_frame_loader_if.sv
// Pixel-RAM write port between the SPI frame loader and the matrix driver.
// The loader drives it as master; the driver (or a bench monitor) listens as slave.
interface spi_frame_loader_if #(
    parameter int ADR_W = 10
);
    logic             we;
    logic [ADR_W-1:0] adr_in;
    logic [2:0]       rgb_in;

    modport master (output we, adr_in, rgb_in);
    modport slave  (input  we, adr_in, rgb_in);
endinterface

// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that receives a 32x32 3-bit-colour frame, two pixels per byte,
// and writes it into the matrix driver's pixel RAM with clean single-cycle strobes.
module spi_frame_loader #(
    parameter int ADR_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sck,
    input  logic                sdi,
    input  logic                cs_n,
    spi_frame_loader_if.master  wr,
    output logic                frame_done,
    output logic                overflow
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP0,
        STROBE0,
        HOLD0,
        SETUP1,
        STROBE1,
        HOLD1
    } state_t;

    localparam logic [ADR_W:0] FULL    = {1'b1, {ADR_W{1'b0}}};
    localparam logic [ADR_W:0] LAST    = FULL - 1'b1;
    localparam logic [ADR_W:0] PTR_ONE = {{ADR_W{1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   cs_s;
    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;

    logic                   active;
    logic [2:0]             bit_cnt;
    logic [5:0]             shreg;
    logic [5:0]             pix_q;
    logic                   byte_valid;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADR_W:0]         ptr;
    logic [ADR_W:0]         ptr_eff;
    logic                   pend;
    logic                   full;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign cs_rise  = cs_s & ~cs_prev;

    // cs resets to 0 so a chip select already low at reset release is not seen as a new frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_sync  <= '0;
            sck_prev <= 1'b0;
            cs_prev  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    // Only the last six bits are kept; bit7 simply shifts out and is never needed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            bit_cnt    <= 3'd0;
            shreg      <= '0;
            pix_q      <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_fall) begin
                active  <= 1'b1;
                bit_cnt <= 3'd0;
            end else if (cs_rise) begin
                active  <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (active && !cs_s && sck_rise) begin
                shreg   <= {shreg[4:0], sdi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    pix_q      <= {shreg[5:3], shreg[1:0], sdi_s};
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    assign ptr_eff = pend ? '0 : ptr;
    assign full    = (ptr_eff == FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (byte_valid && !full) state_d = SETUP0;
            SETUP0:  state_d = STROBE0;
            STROBE0: state_d = HOLD0;
            HOLD0:   state_d = SETUP1;
            SETUP1:  state_d = STROBE1;
            STROBE1: state_d = HOLD1;
            HOLD1:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A frame start seen mid-sequence is parked in pend so the running pair keeps its addresses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            pend       <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            wr.we      <= 1'b0;
            wr.adr_in  <= '0;
            wr.rgb_in  <= '0;
        end else begin
            frame_done <= (state_q == STROBE1) && (ptr == LAST);
            wr.we      <= (state_d == STROBE0) || (state_d == STROBE1);

            if (state_q == IDLE) begin
                if (pend) begin
                    ptr  <= '0;
                    pend <= 1'b0;
                end
                if (byte_valid && full) begin
                    overflow <= 1'b1;
                end
                if (state_d == SETUP0) begin
                    wr.adr_in <= ptr_eff[ADR_W-1:0];
                    wr.rgb_in <= pix_q[5:3];
                end
            end

            if (state_q == HOLD0) begin
                wr.adr_in <= {wr.adr_in[ADR_W-1:1], 1'b1};
                wr.rgb_in <= pix_q[2:0];
            end

            if (state_q == HOLD0 || state_q == HOLD1) begin
                ptr <= ptr + PTR_ONE;
            end

            if (cs_fall) begin
                overflow <= 1'b0;
                if (state_q == IDLE) begin
                    ptr  <= '0;
                    pend <= 1'b0;
                end else begin
                    pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Self-checking bench for spi_frame_loader: a frame-level model predicts every RAM write,
// a negedge monitor records the strobes and checks address/data stability around them.
module tb_spi_frame_loader;

    localparam int ADR_W  = 10;
    localparam int PIXELS = 1 << ADR_W;

    logic clk = 1'b0;
    logic reset_n;
    logic sck;
    logic sdi;
    logic cs_n;
    logic frame_done;
    logic overflow;

    spi_frame_loader_if #(.ADR_W(ADR_W)) wr ();

    spi_frame_loader #(
        .ADR_W       (ADR_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sck        (sck),
        .sdi        (sdi),
        .cs_n       (cs_n),
        .wr         (wr.master),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int  m_ptr = 0;
    bit  m_active = 1'b0;
    bit  m_ovf = 1'b0;
    int  exp_adr[$];
    int  exp_rgb[$];
    int  obs_adr[$];
    int  obs_rgb[$];

    logic             prev_we = 1'b0;
    logic             prev_done = 1'b0;
    logic [ADR_W-1:0] prev_adr = '0;
    logic [2:0]       prev_rgb = '0;
    int               done_cnt = 0;
    int               done_last_adr = -1;
    int               k_wait;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Frame-level model: each accepted byte yields two pixel writes at the next free addresses
    task automatic modelByte(input logic [7:0] b);
        if (!m_active) return;
        if (m_ptr >= PIXELS) begin
            m_ovf = 1'b1;
        end else begin
            exp_adr.push_back(m_ptr);
            exp_rgb.push_back(int'(b[6:4]));
            exp_adr.push_back(m_ptr + 1);
            exp_rgb.push_back(int'(b[2:0]));
            m_ptr += 2;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n, input bit toggle_cs);
        for (int i = 7; i > 7 - n; i--) begin
            sdi = b[i];
            cyc(4);
            sck = 1'b1;
            if (toggle_cs && i == 0) begin
                cyc(1);
                cs_n = 1'b1;
                cyc(3);
                cs_n = 1'b0;
            end else begin
                cyc(4);
            end
            sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        sendBits(b, 8, 1'b0);
        modelByte(b);
    endtask

    task automatic csHigh();
        cyc(4);
        cs_n = 1'b1;
        m_active = 1'b0;
        cyc(4);
    endtask

    task automatic csLow();
        cs_n = 1'b0;
        m_active = 1'b1;
        m_ptr = 0;
        m_ovf = 1'b0;
        cyc(4);
    endtask

    task automatic compareWrites(input string tag);
        int n;
        cyc(20);
        checkOutput({tag, "_count"}, obs_adr.size(), exp_adr.size());
        n = (obs_adr.size() < exp_adr.size()) ? obs_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_adr"}, obs_adr[i], exp_adr[i]);
            checkOutput({tag, "_rgb"}, obs_rgb[i], exp_rgb[i]);
        end
        obs_adr.delete();
        obs_rgb.delete();
        exp_adr.delete();
        exp_rgb.delete();
    endtask

    // Strobe monitor: records each write and checks address/data one cycle either side
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            prev_we   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (wr.we) begin
                if (!prev_we) begin
                    checkOutput("setup_adr", 32'(wr.adr_in), 32'(prev_adr));
                    checkOutput("setup_rgb", 32'(wr.rgb_in), 32'(prev_rgb));
                    obs_adr.push_back(int'(wr.adr_in));
                    obs_rgb.push_back(int'(wr.rgb_in));
                end else begin
                    checkOutput("we_width", 32'(prev_we), 32'd0);
                end
            end else if (prev_we) begin
                checkOutput("hold_adr", 32'(wr.adr_in), 32'(prev_adr));
                checkOutput("hold_rgb", 32'(wr.rgb_in), 32'(prev_rgb));
            end
            if (frame_done) begin
                done_cnt++;
                done_last_adr = (obs_adr.size() > 0) ? obs_adr[$] : -1;
                if (prev_done) checkOutput("done_width", 32'(prev_done), 32'd0);
            end
            prev_we   = wr.we;
            prev_done = frame_done;
        end
        prev_adr = wr.adr_in;
        prev_rgb = wr.rgb_in;
    end

    initial begin
        #900us;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         sel;

        reset_n = 1'b0;
        cs_n    = 1'b1;
        sck     = 1'b0;
        sdi     = 1'b0;
        cyc(5);
        checkOutput("t1_we_in_reset", 32'(wr.we), 32'd0);
        reset_n = 1'b1;
        cyc(20);
        checkOutput("t1_we", 32'(wr.we), 32'd0);
        checkOutput("t1_adr", 32'(wr.adr_in), 32'd0);
        checkOutput("t1_rgb", 32'(wr.rgb_in), 32'd0);
        checkOutput("t1_done", 32'(frame_done), 32'd0);
        checkOutput("t1_ovf", 32'(overflow), 32'd0);
        checkOutput("t1_no_writes", obs_adr.size(), 32'd0);

        $display("[TB] single byte 0x52");
        csLow();
        applyStimulus(8'h52);
        cyc(20);
        checkOutput("t2_rgb0", (obs_rgb.size() > 0) ? obs_rgb[0] : 99, 32'd5);
        checkOutput("t2_rgb1", (obs_rgb.size() > 1) ? obs_rgb[1] : 99, 32'd2);
        compareWrites("t2");

        $display("[TB] full frame of 0x17");
        csHigh();
        csLow();
        done_cnt = 0;
        for (int i = 0; i < PIXELS / 2; i++) applyStimulus(8'h17);
        cyc(20);
        checkOutput("t3_done_cnt", done_cnt, 32'd1);
        checkOutput("t3_done_after", done_last_adr, PIXELS - 1);
        checkOutput("t3_ovf", 32'(overflow), 32'd0);
        compareWrites("t3");

        $display("[TB] overflow");
        applyStimulus(8'h17);
        applyStimulus(8'h17);
        cyc(20);
        checkOutput("t4_ovf_set", 32'(overflow), 32'(m_ovf));
        checkOutput("t4_done_cnt", done_cnt, 32'd1);
        compareWrites("t4_extra");
        csHigh();
        csLow();
        cyc(10);
        checkOutput("t4_ovf_clr", 32'(overflow), 32'd0);
        applyStimulus(8'($urandom));
        compareWrites("t4_new");

        $display("[TB] partial byte discard");
        csHigh();
        csLow();
        sendBits(8'($urandom), 5, 1'b0);
        csHigh();
        csLow();
        applyStimulus(8'h07);
        compareWrites("t5");

        $display("[TB] reset during strobe");
        csHigh();
        csLow();
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        cyc(12);
        fork
            sendBits(8'($urandom), 8, 1'b0);
            begin
                k_wait = 0;
                while (wr.we !== 1'b1 && k_wait < 200) begin
                    cyc(1);
                    k_wait++;
                end
                checkOutput("t6_strobe_seen", 32'(wr.we), 32'd1);
                reset_n = 1'b0;
                #1;
                checkOutput("t6_we_async", 32'(wr.we), 32'd0);
            end
        join
        m_active = 1'b0;
        m_ptr = 0;
        m_ovf = 1'b0;
        cyc(5);
        checkOutput("t6_adr_rst", 32'(wr.adr_in), 32'd0);
        checkOutput("t6_ovf_rst", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        cyc(5);
        applyStimulus(8'($urandom));
        compareWrites("t6_pre");
        csHigh();
        csLow();
        applyStimulus(8'($urandom));
        compareWrites("t6_post");

        $display("[TB] randomized traffic");
        csHigh();
        csLow();
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            b   = 8'($urandom);
            if (sel < 6) begin
                applyStimulus(b);
            end else if (sel < 8) begin
                sendBits(b, int'($urandom_range(1, 7)), 1'b0);
                csHigh();
                csLow();
            end else begin
                sendBits(b, 8, 1'b1);
                modelByte(b);
                m_ptr = 0;
                m_ovf = 1'b0;
            end
        end
        compareWrites("rand");
        checkOutput("rand_ovf", 32'(overflow), 32'(m_ovf));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
